// File: rtl/coincidence_trigger_ctrl_if.sv
// Readout-side event interface for the coincidence trigger controller.
// The controller drives the event (master); readout accepts it (slave).
interface coincidence_trigger_ctrl_if #(
  parameter int N_CH = 4
);
  logic            acq_start;
  logic [N_CH-1:0] hit_pattern;
  logic            event_valid;
  logic            event_ready;

  modport master (
    output acq_start,
    output hit_pattern,
    output event_valid,
    input  event_ready
  );

  modport slave (
    input  acq_start,
    input  hit_pattern,
    input  event_valid,
    output event_ready
  );
endinterface

// File: rtl/coincidence_trigger_ctrl.sv
// Global coincidence trigger: edge detect on masked discriminator pulses, majority
// over a programmable window, event handoff to readout, then a global dead time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | run disabled, edges ignored
// S_ARMED  | waiting for the first masked rising edge
// S_WINDOW | coincidence window open, accumulating hits
// S_EVENT  | event presented to readout, waiting for handshake
// S_DEAD   | global dead time after handshake
module coincidence_trigger_ctrl #(
  parameter int N_CH  = 4,
  parameter int WIN_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       cnt_clear,
  input  logic [N_CH-1:0]            trig_in,
  input  logic [N_CH-1:0]            coinc_mask,
  input  logic [$clog2(N_CH+1)-1:0]  majority,
  input  logic [WIN_W-1:0]           window_len,
  input  logic [29:0]                dead_time,
  output logic                       busy,
  output logic [CNT_W-1:0]           trig_count,
  output logic [CNT_W-1:0]           lost_count,
  coincidence_trigger_ctrl_if.master evt
);

  localparam int MAJ_W = $clog2(N_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WINDOW,
    S_EVENT,
    S_DEAD
  } state_t;

  state_t           state_q, state_d;
  logic [N_CH-1:0]  trig_old_q, trig_old_d;
  logic [N_CH-1:0]  hits_q, hits_d;
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic [29:0]      dcnt_q, dcnt_d;
  logic [N_CH-1:0]  hit_pattern_q, hit_pattern_d;
  logic             acq_start_q, acq_start_d;
  logic             event_valid_q, event_valid_d;
  logic [CNT_W-1:0] trig_count_q, trig_count_d;
  logic [CNT_W-1:0] lost_count_q, lost_count_d;

  logic [N_CH-1:0]  edge_v;
  logic [N_CH-1:0]  hits_now;
  logic [MAJ_W-1:0] maj_eff;
  logic             trig_inc;
  logic             lost_inc;

  function automatic logic [MAJ_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [MAJ_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) begin
      c = c + MAJ_W'(v[i]);
    end
    return c;
  endfunction

  assign edge_v   = trig_in & ~trig_old_q & coinc_mask;
  assign hits_now = hits_q | edge_v;
  assign maj_eff  = (majority == '0) ? MAJ_W'(1) : majority;

  always_comb begin
    state_d       = state_q;
    trig_old_d    = trig_in;
    hits_d        = hits_q;
    wcnt_d        = wcnt_q;
    dcnt_d        = dcnt_q;
    hit_pattern_d = hit_pattern_q;
    acq_start_d   = 1'b0;
    event_valid_d = event_valid_q;
    trig_inc      = 1'b0;
    lost_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARMED;
      end

      S_ARMED: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (|edge_v) begin
          hits_d  = edge_v;
          wcnt_d  = window_len;
          state_d = S_WINDOW;
        end
      end

      S_WINDOW: begin
        if (!enable) begin
          hits_d  = '0;
          state_d = S_IDLE;
        end else if (wcnt_q != '0) begin
          hits_d = hits_now;
          wcnt_d = wcnt_q - WIN_W'(1);
        end else begin
          // Evaluation includes edges arriving on this final window cycle.
          hits_d = '0;
          if (popcount(hits_now) >= maj_eff) begin
            hit_pattern_d = hits_now;
            acq_start_d   = 1'b1;
            event_valid_d = 1'b1;
            trig_inc      = 1'b1;
            state_d       = S_EVENT;
          end else begin
            state_d = S_ARMED;
          end
        end
      end

      S_EVENT: begin
        lost_inc = |edge_v;
        if (event_valid_q && evt.event_ready) begin
          dcnt_d        = dead_time;
          event_valid_d = 1'b0;
          state_d       = S_DEAD;
        end
      end

      S_DEAD: begin
        lost_inc = |edge_v;
        if (dcnt_q == '0) begin
          state_d = enable ? S_ARMED : S_IDLE;
        end else begin
          dcnt_d = dcnt_q - 30'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear wins over increment; both counters stick at all-ones.
    trig_count_d = trig_count_q;
    lost_count_d = lost_count_q;
    if (cnt_clear) begin
      trig_count_d = '0;
      lost_count_d = '0;
    end else begin
      if (trig_inc && !(&trig_count_q)) trig_count_d = trig_count_q + CNT_W'(1);
      if (lost_inc && !(&lost_count_q)) lost_count_d = lost_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      trig_old_q    <= '0;
      hits_q        <= '0;
      wcnt_q        <= '0;
      dcnt_q        <= '0;
      hit_pattern_q <= '0;
      acq_start_q   <= 1'b0;
      event_valid_q <= 1'b0;
      trig_count_q  <= '0;
      lost_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      trig_old_q    <= trig_old_d;
      hits_q        <= hits_d;
      wcnt_q        <= wcnt_d;
      dcnt_q        <= dcnt_d;
      hit_pattern_q <= hit_pattern_d;
      acq_start_q   <= acq_start_d;
      event_valid_q <= event_valid_d;
      trig_count_q  <= trig_count_d;
      lost_count_q  <= lost_count_d;
    end
  end

  assign busy            = (state_q == S_WINDOW) || (state_q == S_EVENT) || (state_q == S_DEAD);
  assign trig_count      = trig_count_q;
  assign lost_count      = lost_count_q;
  assign evt.acq_start   = acq_start_q;
  assign evt.hit_pattern = hit_pattern_q;
  assign evt.event_valid = event_valid_q;

endmodule

// File: tb/tb_coincidence_trigger_ctrl.sv
// Bench for coincidence_trigger_ctrl: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_coincidence_trigger_ctrl;
  localparam int N_CH  = 4;
  localparam int WIN_W = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              cnt_clear = 1'b0;
  logic [N_CH-1:0]   trig_in = '0;
  logic [N_CH-1:0]   coinc_mask = '0;
  logic [2:0]        majority = '0;
  logic [WIN_W-1:0]  window_len = '0;
  logic [29:0]       dead_time = '0;
  logic              busy;
  logic [CNT_W-1:0]  trig_count;
  logic [CNT_W-1:0]  lost_count;

  coincidence_trigger_ctrl_if #(.N_CH(N_CH)) evt_if ();

  coincidence_trigger_ctrl #(.N_CH(N_CH), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cnt_clear  (cnt_clear),
    .trig_in    (trig_in),
    .coinc_mask (coinc_mask),
    .majority   (majority),
    .window_len (window_len),
    .dead_time  (dead_time),
    .busy       (busy),
    .trig_count (trig_count),
    .lost_count (lost_count),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: windows and dead periods are tracked as absolute end cycles.
  bit              m_valid = 0;
  int              m_cyc = 0;
  bit              m_armed = 0;
  int              m_win_until = -1;
  int              m_dead_until = -1;
  bit              m_evt = 0;
  bit              m_acq = 0;
  logic [N_CH-1:0] m_hits = '0;
  logic [N_CH-1:0] m_pat = '0;
  logic [N_CH-1:0] m_old = '0;
  int              m_trig = 0;
  int              m_lost = 0;

  task automatic model_step();
    logic [N_CH-1:0] e;
    int maj;
    bit inc_t, inc_l;
    e     = trig_in & ~m_old & coinc_mask;
    maj   = (majority == 0) ? 1 : int'(majority);
    inc_t = 0;
    inc_l = 0;
    m_acq = 0;
    if (reset) begin
      m_valid = 1; m_armed = 0; m_win_until = -1; m_dead_until = -1; m_evt = 0;
      m_hits = '0; m_pat = '0; m_old = '0; m_trig = 0; m_lost = 0;
      return;
    end
    if (m_evt || m_dead_until >= 0) inc_l = (e != 0);
    if (m_evt) begin
      if (evt_if.event_ready) begin
        m_evt = 0;
        m_dead_until = m_cyc + 1 + int'(dead_time);
      end
    end else if (m_dead_until >= 0) begin
      if (m_cyc == m_dead_until) begin
        m_dead_until = -1;
        m_armed = enable;
      end
    end else if (m_win_until >= 0) begin
      if (!enable) begin
        m_win_until = -1;
        m_hits = '0;
      end else begin
        m_hits |= e;
        if (m_cyc == m_win_until) begin
          m_win_until = -1;
          if ($countones(m_hits) >= maj) begin
            m_evt = 1; m_acq = 1; m_pat = m_hits; inc_t = 1;
          end else begin
            m_armed = 1;
          end
          m_hits = '0;
        end
      end
    end else if (m_armed) begin
      if (!enable) m_armed = 0;
      else if (e != 0) begin
        m_armed = 0;
        m_hits = e;
        m_win_until = m_cyc + 1 + int'(window_len);
      end
    end else if (enable) begin
      m_armed = 1;
    end
    if (cnt_clear) begin
      m_trig = 0;
      m_lost = 0;
    end else begin
      if (inc_t && m_trig < SAT) m_trig++;
      if (inc_l && m_lost < SAT) m_lost++;
    end
    m_old = trig_in;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, (m_win_until >= 0) || m_evt || (m_dead_until >= 0));
      chk("acq_start", evt_if.acq_start, m_acq);
      chk("event_valid", evt_if.event_valid, m_evt);
      chk("hit_pattern", evt_if.hit_pattern, m_pat);
      chk("trig_count", trig_count, m_trig);
      chk("lost_count", lost_count, m_lost);
    end
    model_step();
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acq_seen;
    evt_if.event_ready = 1'b1;
    repeat (3) step();
    reset = 0;

    // single edge, W=0, dead_time=5
    enable = 1; coinc_mask = 4'b1111; majority = 1; window_len = 0; dead_time = 5;
    repeat (2) step();
    trig_in = 4'b0001;
    step();
    chk("d1_busy_win", busy, 1);
    chk("d1_no_acq_early", evt_if.acq_start, 0);
    step();
    chk("d1_acq", evt_if.acq_start, 1);
    chk("d1_valid", evt_if.event_valid, 1);
    chk("d1_pattern", evt_if.hit_pattern, 4'b0001);
    chk("d1_trig", trig_count, 1);
    for (int i = 3; i <= 8; i++) begin
      step();
      chk("d1_busy_dead", busy, 1);
      chk("d1_acq_once", evt_if.acq_start, 0);
    end
    step();
    chk("d1_rearmed", busy, 0);
    trig_in = 0;
    repeat (2) step();

    // majority 2, W=3: second edge on last window cycle is accepted
    majority = 2; window_len = 3;
    trig_in = 4'b0010;
    repeat (4) step();
    trig_in = 4'b1010;
    step();
    chk("d2_acq", evt_if.acq_start, 1);
    chk("d2_pattern", evt_if.hit_pattern, 4'b1010);
    chk("d2_trig", trig_count, 2);
    trig_in = 0;
    repeat (10) step();
    // second edge one cycle too late
    trig_in = 4'b0010;
    repeat (5) step();
    trig_in = 4'b1010;
    acq_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (evt_if.acq_start) acq_seen++;
    end
    chk("d2_late_no_acq", acq_seen, 0);
    chk("d2_late_trig", trig_count, 2);
    trig_in = 0;
    repeat (3) step();

    // readout stall of 8 cycles with lost edges and enable drop
    majority = 1; window_len = 0; dead_time = 3; evt_if.event_ready = 0;
    cnt_clear = 1;
    step();
    cnt_clear = 0;
    trig_in = 4'b0001;
    step();
    trig_in = 0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("d3_valid_hold", evt_if.event_valid, 1);
      chk("d3_pattern_hold", evt_if.hit_pattern, 4'b0001);
      if (i == 1 || i == 3) trig_in = 4'b0100;
      else trig_in = 0;
      if (i == 4) enable = 0;
      if (i == 7) evt_if.event_ready = 1;
      step();
    end
    chk("d3_valid_drop", evt_if.event_valid, 0);
    chk("d3_dead_busy", busy, 1);
    chk("d3_trig", trig_count, 1);
    repeat (4) step();
    chk("d3_idle", busy, 0);
    chk("d3_lost", lost_count, 2);
    trig_in = 4'b0001;
    step();
    step();
    chk("d3_idle_ignores", busy, 0);
    trig_in = 0;

    // mask restricts participation to ch2
    enable = 1; coinc_mask = 4'b0100; window_len = 1; dead_time = 2;
    cnt_clear = 1;
    step();
    cnt_clear = 0;
    acq_seen = 0;
    for (int i = 0; i < 12; i++) begin
      trig_in = (i % 3 == 0) ? 4'b0000 : 4'b1011;
      step();
      if (busy) acq_seen++;
    end
    chk("d4_masked_quiet", acq_seen, 0);
    trig_in = 0;
    step();
    acq_seen = 0;
    trig_in = 4'b0100;
    for (int i = 0; i < 100; i++) begin
      step();
      if (evt_if.acq_start) acq_seen++;
    end
    chk("d4_one_event", acq_seen, 1);
    chk("d4_trig", trig_count, 1);
    trig_in = 0;
    repeat (2) step();

    // saturation and clear-vs-increment priority
    coinc_mask = 4'b1111; window_len = 0; dead_time = 0;
    for (int ev = 0; ev < 20; ev++) begin
      trig_in = 4'b0001;
      step();
      trig_in = 0;
      repeat (4) step();
    end
    chk("d5_saturated", trig_count, SAT);
    trig_in = 4'b0001;
    step();
    trig_in = 0;
    cnt_clear = 1;
    step();
    cnt_clear = 0;
    chk("d5_clear_priority", trig_count, 0);
    chk("d5_event_despite_clear", evt_if.acq_start, 1);
    repeat (4) step();

    // reset during WINDOW, then during EVENT
    window_len = 10;
    trig_in = 4'b0011;
    repeat (3) step();
    reset = 1;
    step();
    chk("d6_win_busy", busy, 0);
    chk("d6_win_valid", evt_if.event_valid, 0);
    chk("d6_win_pattern", evt_if.hit_pattern, 0);
    chk("d6_win_trig", trig_count, 0);
    reset = 0; trig_in = 0;
    acq_seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (evt_if.acq_start) acq_seen++;
    end
    chk("d6_no_acq_after_reset", acq_seen, 0);
    window_len = 0; evt_if.event_ready = 0;
    trig_in = 4'b1000;
    repeat (3) step();
    chk("d6_in_event", evt_if.event_valid, 1);
    reset = 1;
    step();
    chk("d6_evt_valid", evt_if.event_valid, 0);
    chk("d6_evt_acq", evt_if.acq_start, 0);
    chk("d6_evt_busy", busy, 0);
    chk("d6_evt_pattern", evt_if.hit_pattern, 0);
    reset = 0; trig_in = 0; evt_if.event_ready = 1;
    repeat (2) step();

    // randomized traffic against the model
    for (int c = 0; c < 5000; c++) begin
      if (c % 60 == 0) begin
        coinc_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
        majority   = 3'($urandom_range(0, 4));
        window_len = 8'($urandom_range(0, 6));
        dead_time  = 30'($urandom_range(0, 8));
      end
      for (int b = 0; b < N_CH; b++) begin
        if ($urandom_range(0, 9) == 0) trig_in[b] = ~trig_in[b];
      end
      evt_if.event_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 99) < 96);
      cnt_clear = ($urandom_range(0, 99) < 2);
      reset     = ($urandom_range(0, 999) < 4);
      step();
    end
    reset = 0; cnt_clear = 0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
